// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: latches decoded ID fields, resolves the destination and the EX forwarding selects, and bubbles load-use hazards.
// Latency: ID fields appear on ex_* one cycle after capture; load_use_o is combinational.
// Backpressure: stall_i freezes every register; load_use_o asks ID to hold while this stage inserts a bubble.
module idex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_W-1:0]  id_rs_i,
    input  logic [REG_W-1:0]  id_rt_i,
    input  logic [REG_W-1:0]  id_rd_i,
    input  logic [1:0]        id_regdst_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_alusrc_i,
    input  logic              id_wen_i,
    input  logic              id_mem_read_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              mem_wen_i,
    input  logic [REG_W-1:0]  mem_wreg_i,
    output logic              load_use_o,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_wen_o,
    output logic              ex_mem_read_o,
    output logic [REG_W-1:0]  ex_wreg_o,
    output logic [1:0]        ex_fwd_a_sel_o,
    output logic [1:0]        ex_fwd_b_sel_o,
    output logic [1:0]        ex_fwd_st_sel_o
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
        logic              wen;
        logic              mem_read;
        logic [REG_W-1:0]  wreg;
        logic [1:0]        fwd_a;
        logic [1:0]        fwd_b;
        logic [1:0]        fwd_st;
    } ex_t;

    ex_t              ex_q;
    ex_t              ex_d;
    logic [REG_W-1:0] wreg_d;
    logic [1:0]       fwd_rs;
    logic [1:0]       fwd_rt;

    // The instruction now in EX reaches MEM on this edge, so it outranks the one already in MEM.
    function automatic logic [1:0] fwd_sel(
        input logic             uses,
        input logic [REG_W-1:0] src,
        input logic             ex_v,
        input logic             ex_w,
        input logic [REG_W-1:0] ex_r,
        input logic             m_w,
        input logic [REG_W-1:0] m_r
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (uses && src != '0) begin
            if (ex_v && ex_w && ex_r == src)
                sel = SEL_EXMEM;
            else if (m_w && m_r == src)
                sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    // Hazard: consumer in ID needs a value a load in EX has not produced yet.
    assign load_use_o = ~stall_i & id_valid_i & ex_q.valid & ex_q.mem_read &
                        (ex_q.wreg != '0) &
                        ((id_uses_rs_i & (id_rs_i == ex_q.wreg)) |
                         (id_uses_rt_i & (id_rt_i == ex_q.wreg)));

    // Destination mux; 11 means no architectural destination.
    always_comb begin
        wreg_d = '0;
        case (id_regdst_i)
            2'b00:   wreg_d = id_rt_i;
            2'b01:   wreg_d = id_rd_i;
            2'b10:   wreg_d = REG_W'(31);
            default: wreg_d = '0;
        endcase
    end

    // Build the value captured into EX, including forwarding selects resolved now.
    always_comb begin
        fwd_rs = fwd_sel(id_uses_rs_i, id_rs_i, ex_q.valid, ex_q.wen, ex_q.wreg,
                         mem_wen_i, mem_wreg_i);
        fwd_rt = fwd_sel(id_uses_rt_i, id_rt_i, ex_q.valid, ex_q.wen, ex_q.wreg,
                         mem_wen_i, mem_wreg_i);
        ex_d          = '0;
        ex_d.valid    = id_valid_i;
        ex_d.pc       = id_pc_i;
        ex_d.rs_data  = id_rs_data_i;
        ex_d.rt_data  = id_rt_data_i;
        ex_d.imm      = id_imm_i;
        ex_d.ctrl     = id_ctrl_i;
        ex_d.wen      = id_wen_i & id_valid_i & (wreg_d != '0);
        ex_d.mem_read = id_mem_read_i;
        ex_d.wreg     = wreg_d;
        ex_d.fwd_a    = fwd_rs;
        ex_d.fwd_b    = id_alusrc_i ? SEL_IMM : fwd_rt;
        ex_d.fwd_st   = fwd_rt;
    end

    // Pipeline register: reset > flush > stall > load-use bubble > capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ex_q <= '0;
        else if (flush_i)
            ex_q <= '0;
        else if (stall_i)
            ex_q <= ex_q;
        else if (load_use_o)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign ex_valid_o      = ex_q.valid;
    assign ex_pc_o         = ex_q.pc;
    assign ex_rs_data_o    = ex_q.rs_data;
    assign ex_rt_data_o    = ex_q.rt_data;
    assign ex_imm_o        = ex_q.imm;
    assign ex_ctrl_o       = ex_q.ctrl;
    assign ex_wen_o        = ex_q.wen;
    assign ex_mem_read_o   = ex_q.mem_read;
    assign ex_wreg_o       = ex_q.wreg;
    assign ex_fwd_a_sel_o  = ex_q.fwd_a;
    assign ex_fwd_b_sel_o  = ex_q.fwd_b;
    assign ex_fwd_st_sel_o = ex_q.fwd_st;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: scenario tasks push expected EX contents into a scoreboard queue and compare after each edge.
// Latency: every expectation is popped one clock after its stimulus is driven.
// Backpressure: stall and load-use scenarios drive stall_i and check the held or bubbled contents.
module tb_idex_stage_reg;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        id_valid_i = 1'b0;
    logic [31:0] id_pc_i = '0;
    logic [31:0] id_rs_data_i = '0;
    logic [31:0] id_rt_data_i = '0;
    logic [31:0] id_imm_i = '0;
    logic [4:0]  id_rs_i = '0;
    logic [4:0]  id_rt_i = '0;
    logic [4:0]  id_rd_i = '0;
    logic [1:0]  id_regdst_i = '0;
    logic        id_uses_rs_i = 1'b0;
    logic        id_uses_rt_i = 1'b0;
    logic        id_alusrc_i = 1'b0;
    logic        id_wen_i = 1'b0;
    logic        id_mem_read_i = 1'b0;
    logic [15:0] id_ctrl_i = '0;
    logic        mem_wen_i = 1'b0;
    logic [4:0]  mem_wreg_i = '0;
    logic        load_use_o;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [31:0] ex_rs_data_o;
    logic [31:0] ex_rt_data_o;
    logic [31:0] ex_imm_o;
    logic [15:0] ex_ctrl_o;
    logic        ex_wen_o;
    logic        ex_mem_read_o;
    logic [4:0]  ex_wreg_o;
    logic [1:0]  ex_fwd_a_sel_o;
    logic [1:0]  ex_fwd_b_sel_o;
    logic [1:0]  ex_fwd_st_sel_o;

    int checks = 0;
    int errors = 0;

    logic [157:0] sb[$];
    logic [157:0] exp_v;
    logic [157:0] obs;
    localparam logic [157:0] ZERO = '0;

    assign obs = {ex_valid_o, ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_ctrl_o,
                  ex_wen_o, ex_mem_read_o, ex_wreg_o, ex_fwd_a_sel_o, ex_fwd_b_sel_o,
                  ex_fwd_st_sel_o};

    idex_stage_reg dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs_data_i(id_rs_data_i),
        .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regdst_i(id_regdst_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
        .id_alusrc_i(id_alusrc_i), .id_wen_i(id_wen_i), .id_mem_read_i(id_mem_read_i),
        .id_ctrl_i(id_ctrl_i), .mem_wen_i(mem_wen_i), .mem_wreg_i(mem_wreg_i),
        .load_use_o(load_use_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
        .ex_ctrl_o(ex_ctrl_o), .ex_wen_o(ex_wen_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_wreg_o(ex_wreg_o), .ex_fwd_a_sel_o(ex_fwd_a_sel_o),
        .ex_fwd_b_sel_o(ex_fwd_b_sel_o), .ex_fwd_st_sel_o(ex_fwd_st_sel_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected EX image for an instruction whose data fields derive from its pc.
    function automatic logic [157:0] id_exp(input logic v, input logic [31:0] pc,
                                            input logic w, mr, input logic [4:0] wr,
                                            input logic [1:0] fa, fb, fs);
        logic [15:0] c;
        c = pc[15:0] ^ 16'ha5a5;
        return {v, pc, pc + 32'd1, pc + 32'd2, pc + 32'd3, c, w, mr, wr, fa, fb, fs};
    endfunction

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt, rd,
                          input logic [1:0] rdst, input logic urs, urt, asrc, w, mr);
        id_valid_i = v;       id_pc_i = pc;
        id_rs_data_i = pc + 32'd1; id_rt_data_i = pc + 32'd2; id_imm_i = pc + 32'd3;
        id_ctrl_i = pc[15:0] ^ 16'ha5a5;
        id_rs_i = rs; id_rt_i = rt; id_rd_i = rd; id_regdst_i = rdst;
        id_uses_rs_i = urs; id_uses_rt_i = urt; id_alusrc_i = asrc;
        id_wen_i = w; id_mem_read_i = mr;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (obs !== ZERO) begin errors++; $display("FAIL reset_initial: got %h want %h", obs, ZERO); end
        @(negedge clk_i); rst_i = 1'b0;
        set_id(1, 32'd100, 5'd1, 5'd2, 5'd3, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd100, 1, 0, 5'd3, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_load: got %h want %h", obs, exp_v); end
        #2 rst_i = 1'b1;
        #1; checks++;
        if (obs !== ZERO || ex_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_async: got %h want %h", obs, ZERO);
        end
        #2 rst_i = 1'b0;
        #1; checks++;
        if (obs !== ZERO) begin errors++; $display("FAIL reset_release_hold: got %h want %h", obs, ZERO); end
        flush_i = 1'b1;
        sb.push_back(ZERO);
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL flush_bubble: got %h want %h", obs, exp_v); end
        flush_i = 1'b0;
    endtask

    task automatic test_fwd_ex();
        set_id(1, 32'd200, 5'd1, 5'd2, 5'd3, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd200, 1, 0, 5'd3, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fwd_ex_add: got %h want %h", obs, exp_v); end
        set_id(1, 32'd210, 5'd3, 5'd5, 5'd4, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd210, 1, 0, 5'd4, 2'b01, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fwd_ex_sub: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_fwd_priority();
        set_id(1, 32'd300, 5'd7, 5'd8, 5'd3, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd300, 1, 0, 5'd3, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL prio_writer: got %h want %h", obs, exp_v); end
        mem_wen_i = 1'b1; mem_wreg_i = 5'd3;
        set_id(1, 32'd310, 5'd3, 5'd3, 5'd9, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd310, 1, 0, 5'd9, 2'b01, 2'b01, 2'b01));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL prio_ex_over_mem: got %h want %h", obs, exp_v); end
        set_id(1, 32'd320, 5'd3, 5'd0, 5'd10, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd320, 1, 0, 5'd10, 2'b10, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL prio_mem_only: got %h want %h", obs, exp_v); end
        mem_wen_i = 1'b0; mem_wreg_i = 5'd0;
    endtask

    task automatic test_load_use();
        set_id(1, 32'd400, 5'd1, 5'd3, 5'd0, 2'b00, 1, 0, 1, 1, 1);
        sb.push_back(id_exp(1, 32'd400, 1, 1, 5'd3, 2'b00, 2'b11, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lu_load: got %h want %h", obs, exp_v); end
        set_id(1, 32'd410, 5'd3, 5'd1, 5'd6, 2'b01, 1, 1, 0, 1, 0);
        #1; checks++;
        if (load_use_o !== 1'b1) begin errors++; $display("FAIL lu_detect: got %b want 1", load_use_o); end
        stall_i = 1'b1;
        #1; checks++;
        if (load_use_o !== 1'b0) begin errors++; $display("FAIL lu_stall_mask: got %b want 0", load_use_o); end
        stall_i = 1'b0;
        sb.push_back(ZERO);
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lu_bubble: got %h want %h", obs, exp_v); end
        checks++;
        if (load_use_o !== 1'b0) begin errors++; $display("FAIL lu_clear: got %b want 0", load_use_o); end
        mem_wen_i = 1'b1; mem_wreg_i = 5'd3;
        sb.push_back(id_exp(1, 32'd410, 1, 0, 5'd6, 2'b10, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lu_resolve: got %h want %h", obs, exp_v); end
        mem_wen_i = 1'b0; mem_wreg_i = 5'd0;
    endtask

    task automatic test_stall();
        set_id(1, 32'd600, 5'd6, 5'd2, 5'd7, 2'b01, 1, 1, 0, 1, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(id_exp(1, 32'd410, 1, 0, 5'd6, 2'b10, 2'b00, 2'b00));
            step();
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, exp_v); end
        end
        flush_i = 1'b1;
        sb.push_back(ZERO);
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_flush: got %h want %h", obs, exp_v); end
        flush_i = 1'b0; stall_i = 1'b0;
        sb.push_back(id_exp(1, 32'd600, 1, 0, 5'd7, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_release: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_zero_dest();
        set_id(1, 32'd700, 5'd1, 5'd2, 5'd9, 2'b11, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd700, 0, 0, 5'd0, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL zero_regdst11: got %h want %h", obs, exp_v); end
        set_id(1, 32'd710, 5'd1, 5'd2, 5'd0, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd710, 0, 0, 5'd0, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL zero_rd0: got %h want %h", obs, exp_v); end
        mem_wen_i = 1'b1; mem_wreg_i = 5'd0;
        set_id(1, 32'd720, 5'd0, 5'd0, 5'd8, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd720, 1, 0, 5'd8, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL zero_read_r0: got %h want %h", obs, exp_v); end
        mem_wen_i = 1'b0;
        set_id(0, 32'd730, 5'd1, 5'd2, 5'd5, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(0, 32'd730, 0, 0, 5'd5, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL invalid_wen: got %h want %h", obs, exp_v); end
        set_id(1, 32'd740, 5'd0, 5'd0, 5'd0, 2'b10, 0, 0, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd740, 1, 0, 5'd31, 2'b00, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL link_r31: got %h want %h", obs, exp_v); end
        set_id(1, 32'd750, 5'd31, 5'd3, 5'd12, 2'b01, 1, 1, 0, 1, 0);
        sb.push_back(id_exp(1, 32'd750, 1, 0, 5'd12, 2'b01, 2'b00, 2'b00));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fwd_r31: got %h want %h", obs, exp_v); end
        mem_wen_i = 1'b1; mem_wreg_i = 5'd3;
        set_id(1, 32'd760, 5'd2, 5'd3, 5'd0, 2'b00, 1, 1, 1, 0, 0);
        sb.push_back(id_exp(1, 32'd760, 0, 0, 5'd3, 2'b00, 2'b11, 2'b10));
        step();
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL store_sel: got %h want %h", obs, exp_v); end
        mem_wen_i = 1'b0; mem_wreg_i = 5'd0;
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_priority();
        test_load_use();
        test_stall();
        test_zero_dest();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
